// File: rtl/pwm_capture_if.sv
// Avalon-MM slave bus bundle for the PWM capture peripheral.
// Zero-wait handshake: a write commits on the clk edge where chipselect&write is high; readdata is valid in the same cycle as chipselect&read; there is no waitrequest.
interface pwm_capture_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, write, writedata, read, byteenable,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write, writedata, read, byteenable,
    output readdata
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of pwm_in in clk cycles and counts completed periods.
// Results are exposed as Avalon-MM registers with an optional level interrupt.
module pwm_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] TIMEOUT     = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  pwm_capture_if.slave     avs,
  input  logic             pwm_in,
  output logic             irq,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state_q;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        s, s_d, rise;
  logic        enable_q, irq_en_q, valid_q, overflow_q, irq_q;
  logic [31:0] period_q, high_q, count_q, cnt_q, hcnt_q;
  logic        wr, ctrl_wr, clr_valid, clr_ovf;
  logic        unused_bits;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  assign wr        = avs.chipselect & avs.write;
  assign ctrl_wr   = wr & (avs.address == 3'd0) & avs.byteenable[0];
  assign clr_valid = wr & (avs.address == 3'd1) & avs.byteenable[0] & avs.writedata[0];
  assign clr_ovf   = wr & (avs.address == 3'd1) & avs.byteenable[0] & avs.writedata[1];

  assign unused_bits = ^{avs.writedata[31:2], avs.byteenable[3:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      else                 sync_q <= pwm_in;
      s_d <= s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      period_q   <= '0;
      high_q     <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      hcnt_q     <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= avs.writedata[0];
        irq_en_q <= avs.writedata[1];
      end
      // CPU clears come first so that a hardware set later in this block wins.
      if (clr_valid) valid_q    <= 1'b0;
      if (clr_ovf)   overflow_q <= 1'b0;
      irq_q <= irq_en_q & (valid_q | overflow_q);

      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          hcnt_q <= '0;
          if (enable_q) state_q <= ARM;
        end
        ARM: begin
          if (!enable_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
          end else if (rise) begin
            cnt_q   <= 32'd1;
            hcnt_q  <= 32'd1;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (!enable_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
          end else if (rise) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            count_q  <= count_q + 32'd1;
            cnt_q    <= 32'd1;
            hcnt_q   <= 32'd1;
          end else if (cnt_q == TIMEOUT) begin
            // No edge within TIMEOUT cycles: flag it and wait for a fresh edge.
            overflow_q <= 1'b1;
            state_q    <= ARM;
            cnt_q      <= '0;
            hcnt_q     <= '0;
          end else begin
            cnt_q  <= cnt_q + 32'd1;
            hcnt_q <= hcnt_q + {31'b0, s};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    avs.readdata = '0;
    if (avs.chipselect && avs.read) begin
      case (avs.address)
        3'd0:    avs.readdata = {30'b0, irq_en_q, enable_q};
        3'd1:    avs.readdata = {29'b0, s, overflow_q, valid_q};
        3'd2:    avs.readdata = period_q;
        3'd3:    avs.readdata = high_q;
        3'd4:    avs.readdata = count_q;
        default: avs.readdata = '0;
      endcase
    end
  end

  assign irq       = irq_q;
  assign dbg_state = state_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Avalon-MM slave peripheral that sits directly downstream of the PWM generator IP. Its pwm_in is wired to the generator's PWM_out, or to an external PWM pin.
- Measures the input's period and high time in clk cycles and counts completed periods. Results are exposed to the Nios II CPU as registers, and an optional level interrupt is raised on each new measurement.
- Used for closed-loop self-check of the PWM generator and for reading external PWM sensors.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on pwm_in (legal range 2..4)
TIMEOUT, 32'hFFFF_FFFF, cycle count without a rising edge that flags overflow and re-arms

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
chipselect  input  1  Avalon slave select
address  input  3  word register address
write  input  1  write strobe
writedata  input  32  write data
read  input  1  read strobe
byteenable  input  4  byte lanes for write
readdata  output  32  read data
pwm_in  input  1  PWM signal to measure (may be asynchronous)
irq  output  1  level interrupt

Behaviour:
- Reset values: readdata=0, irq=0, all registers=0, FSM=IDLE.
- Register map:
  - 0 CONTROL, RW: bit0 enable, bit1 irq_en. Written only when byteenable[0]=1.
  - 1 STATUS: bit0 valid (W1C), bit1 overflow (W1C), bit2 synchronised level (RO). W1C acts only when byteenable[0]=1.
  - 2 PERIOD, RO.
  - 3 HIGH, RO.
  - 4 COUNT, RO: completed periods, wraps modulo 2^32.
  - 5..7 read 0.
  - Writes to RO or unused addresses are ignored.
- Reads:
  - Combinational: readdata = selected register when chipselect&read, else 0.
  - Zero wait states.
- Input path:
  - pwm_in passes through SYNC_STAGES flops to give level s, plus one more flop to give s_d.
  - rise = s & ~s_d.
  - Latency from a pin edge to rise is SYNC_STAGES+1 cycles.
- FSM:
  - IDLE: cnt=0, hcnt=0. Go to ARM when enable=1.
  - ARM: on rise, set cnt<=1, hcnt<=1, go to MEASURE.
  - MEASURE, when rise occurs:
    - PERIOD<=cnt, HIGH<=hcnt, valid<=1.
    - COUNT<=COUNT+1.
    - cnt<=1, hcnt<=1.
  - MEASURE, when rise does not occur:
    - cnt<=cnt+1, hcnt<=hcnt+s.
    - If cnt==TIMEOUT: overflow<=1 and go to ARM. PERIOD, HIGH and COUNT are unchanged.
  - Any state with enable=0: go to IDLE next cycle. cnt and hcnt clear; PERIOD, HIGH, COUNT and STATUS are held.
- Arithmetic:
  - All counters are 32-bit unsigned.
  - cnt never exceeds TIMEOUT.
  - hcnt<=cnt always holds.
  - Duty 100% or 0% (no edges) leads to overflow, not a bogus measurement.
- Simultaneous events:
  - A hardware set of valid or overflow in the same cycle as a W1C write: set wins.
  - A CPU write of enable=0 in the same cycle as rise: the capture still completes that cycle, then the FSM goes to IDLE.
- irq = irq_en & (valid | overflow), registered one cycle after the status change.
- Asynchronous reset mid-measurement: everything returns to reset values immediately. The first capture after re-enable requires two rising edges.

Test Plan:
- Reset then read all addresses 0..7 -> every read returns 0; irq=0.
- Drive pwm_in from the PWM generator with clock_divide=9, duty=3, enable=1, then write CONTROL=1 -> after the second rising edge PERIOD=10, HIGH=4, STATUS.valid=1; COUNT increments by 1 every 10 cycles.
- Hold pwm_in=1 after one edge, with TIMEOUT=100 -> STATUS.overflow=1 exactly 100 cycles after the capture start, FSM re-armed. Then toggle pwm_in at 6 high / 2 low -> PERIOD=8, HIGH=6 after two further rising edges.
- With CONTROL=3 and a capture occurring -> irq=1 one cycle after valid sets. Write STATUS=1 -> irq=0. Repeat the W1C write in the exact cycle of the next capture -> valid stays 1.
- Partial writes: write CONTROL=0x3 with byteenable=4'b1110 -> CONTROL unchanged. Write PERIOD=0xDEAD -> PERIOD unchanged.
- Deassert enable mid-measurement, then re-enable -> PERIOD/HIGH hold their old values until two new rising edges. Assert reset_n=0 mid-period -> all registers are 0 immediately.
